// File: rtl/hazard_ctrl_unit_if.sv
// Decode/execute hazard signals and pipeline-control outputs of hazard_ctrl_unit.
// master drives the pipeline-side inputs; slave is the hazard unit itself.
interface hazard_ctrl_unit_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic [REG_AW-1:0] rs1_if_id;
  logic [REG_AW-1:0] rs2_if_id;
  logic              rs1_used;
  logic              rs2_used;
  logic [REG_AW-1:0] rd_id_ex;
  logic              memread_id_ex;
  logic              branch_taken;
  logic              mem_busy;
  logic              cnt_clr;
  logic              stall;
  logic              pc_write;
  logic              if_id_write;
  logic              id_ex_write;
  logic              id_ex_bubble;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic [CNT_W-1:0]  stall_count;

  modport master (
    output rs1_if_id, rs2_if_id, rs1_used, rs2_used, rd_id_ex, memread_id_ex,
           branch_taken, mem_busy, cnt_clr,
    input  stall, pc_write, if_id_write, id_ex_write, id_ex_bubble,
           if_id_flush, id_ex_flush, stall_count
  );

  modport slave (
    input  rs1_if_id, rs2_if_id, rs1_used, rs2_used, rd_id_ex, memread_id_ex,
           branch_taken, mem_busy, cnt_clr,
    output stall, pc_write, if_id_write, id_ex_write, id_ex_bubble,
           if_id_flush, id_ex_flush, stall_count
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Load-use hazard and pipeline-control unit: multi-cycle load stall FSM,
// branch flush, memory-wait freeze and a saturating lost-cycle counter.
module hazard_ctrl_unit #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input logic         clk,
  input logic         rst,
  hazard_ctrl_unit_if.slave hif
);

  localparam int WCNT_W = $clog2(LOAD_LAT) + 1;

  typedef enum logic {IDLE, LOAD_WAIT} state_t;

  state_t              state_p0;
  logic [WCNT_W-1:0]   wcnt_p0;
  logic [CNT_W-1:0]    stall_count_p0;
  logic [REG_AW-1:0]   rd_ex;
  logic                rs1_hit;
  logic                rs2_hit;
  logic                hazard;
  logic                stall_now;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign rd_ex   = hif.rd_id_ex;
  assign rs1_hit = hif.rs1_used && (hif.rs1_if_id == rd_ex);
  assign rs2_hit = hif.rs2_used && (hif.rs2_if_id == rd_ex);
  assign hazard  = hif.memread_id_ex && (rd_ex != '0) && (rs1_hit || rs2_hit);

  // Control outputs: reset forces a free-running pipeline, then
  // freeze > flush > load stall > normal flow.
  always_comb begin
    stall_now        = 1'b0;
    hif.pc_write     = 1'b1;
    hif.if_id_write  = 1'b1;
    hif.id_ex_write  = 1'b1;
    hif.id_ex_bubble = 1'b0;
    hif.if_id_flush  = 1'b0;
    hif.id_ex_flush  = 1'b0;
    if (rst) begin
      if (hif.mem_busy) begin
        hif.pc_write    = 1'b0;
        hif.if_id_write = 1'b0;
        hif.id_ex_write = 1'b0;
      end else if (hif.branch_taken) begin
        hif.if_id_flush = 1'b1;
        hif.id_ex_flush = 1'b1;
      end else if (state_p0 == LOAD_WAIT || hazard) begin
        stall_now        = 1'b1;
        hif.pc_write     = 1'b0;
        hif.if_id_write  = 1'b0;
        hif.id_ex_bubble = 1'b1;
      end
    end
    hif.stall = stall_now;
  end

  // Stall FSM: wcnt counts the remaining LOAD_WAIT cycles; a freeze holds it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_p0 <= IDLE;
      wcnt_p0  <= '0;
    end else if (!hif.mem_busy) begin
      if (hif.branch_taken) begin
        state_p0 <= IDLE;
        wcnt_p0  <= '0;
      end else if (state_p0 == LOAD_WAIT) begin
        if (wcnt_p0 == WCNT_W'(1)) begin
          state_p0 <= IDLE;
          wcnt_p0  <= '0;
        end else begin
          wcnt_p0 <= wcnt_p0 - 1'b1;
        end
      end else if (hazard && (LOAD_LAT > 1)) begin
        state_p0 <= LOAD_WAIT;
        wcnt_p0  <= WCNT_W'(LOAD_LAT - 1);
      end
    end
  end

  // Lost-cycle counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_count_p0 <= '0;
    end else if (hif.cnt_clr) begin
      stall_count_p0 <= '0;
    end else if (stall_now || hif.mem_busy) begin
      stall_count_p0 <= sat_inc(stall_count_p0);
    end
  end

  assign hif.stall_count = stall_count_p0;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: three instances (LOAD_LAT 1/3/2, one with a 4-bit
// counter) share one directed stimulus and are checked against a cycle model.
module tb_hazard_ctrl_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] rs1, rs2, rd;
  logic       rs1_used, rs2_used, memread, br, mb, clr;

  hazard_ctrl_unit_if #(.REG_AW(5), .CNT_W(16)) i0 ();
  hazard_ctrl_unit_if #(.REG_AW(5), .CNT_W(16)) i1 ();
  hazard_ctrl_unit_if #(.REG_AW(5), .CNT_W(4))  i2 ();

  hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(16)) u0 (.clk(clk), .rst(rst), .hif(i0.slave));
  hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(16)) u1 (.clk(clk), .rst(rst), .hif(i1.slave));
  hazard_ctrl_unit #(.REG_AW(5), .LOAD_LAT(2), .CNT_W(4))  u2 (.clk(clk), .rst(rst), .hif(i2.slave));

  assign i0.rs1_if_id = rs1;  assign i1.rs1_if_id = rs1;  assign i2.rs1_if_id = rs1;
  assign i0.rs2_if_id = rs2;  assign i1.rs2_if_id = rs2;  assign i2.rs2_if_id = rs2;
  assign i0.rs1_used  = rs1_used; assign i1.rs1_used = rs1_used; assign i2.rs1_used = rs1_used;
  assign i0.rs2_used  = rs2_used; assign i1.rs2_used = rs2_used; assign i2.rs2_used = rs2_used;
  assign i0.rd_id_ex  = rd;   assign i1.rd_id_ex  = rd;   assign i2.rd_id_ex  = rd;
  assign i0.memread_id_ex = memread; assign i1.memread_id_ex = memread; assign i2.memread_id_ex = memread;
  assign i0.branch_taken  = br; assign i1.branch_taken = br; assign i2.branch_taken = br;
  assign i0.mem_busy  = mb;   assign i1.mem_busy  = mb;   assign i2.mem_busy  = mb;
  assign i0.cnt_clr   = clr;  assign i1.cnt_clr   = clr;  assign i2.cnt_clr   = clr;

  // {stall, pc_write, if_id_write, id_ex_write, id_ex_bubble, if_id_flush, id_ex_flush}
  localparam logic [6:0] NORMAL = 7'b0111000;
  localparam logic [6:0] FREEZE = 7'b0000000;
  localparam logic [6:0] FLUSH  = 7'b0111011;
  localparam logic [6:0] STALL  = 7'b1001100;

  logic [6:0]  act_ctl [3];
  logic [15:0] act_cnt [3];
  assign act_ctl[0] = {i0.stall, i0.pc_write, i0.if_id_write, i0.id_ex_write, i0.id_ex_bubble, i0.if_id_flush, i0.id_ex_flush};
  assign act_ctl[1] = {i1.stall, i1.pc_write, i1.if_id_write, i1.id_ex_write, i1.id_ex_bubble, i1.if_id_flush, i1.id_ex_flush};
  assign act_ctl[2] = {i2.stall, i2.pc_write, i2.if_id_write, i2.id_ex_write, i2.id_ex_bubble, i2.if_id_flush, i2.id_ex_flush};
  assign act_cnt[0] = i0.stall_count;
  assign act_cnt[1] = i1.stall_count;
  assign act_cnt[2] = {12'b0, i2.stall_count};

  // Model: rem = forced stall cycles still owed after the current hazard cycle.
  int lat  [3] = '{1, 3, 2};
  int cmax [3] = '{65535, 65535, 15};
  int rem  [3] = '{0, 0, 0};
  int mcnt [3] = '{0, 0, 0};
  int tests = 0;
  int fails = 0;

  function automatic bit hz_f();
    return memread && (rd != 0) &&
           ((rs1_used && rs1 == rd) || (rs2_used && rs2 == rd));
  endfunction

  function automatic logic [6:0] exp_ctl(input int r);
    if (!rst)            return NORMAL;
    else if (mb)         return FREEZE;
    else if (br)         return FLUSH;
    else if (r > 0 || hz_f()) return STALL;
    else                 return NORMAL;
  endfunction

  always @(posedge clk or negedge rst) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst) begin
        rem[k]  <= 0;
        mcnt[k] <= 0;
      end else begin
        if (!mb && br)                rem[k] <= 0;
        else if (!mb && rem[k] > 0)   rem[k] <= rem[k] - 1;
        else if (!mb && hz_f())       rem[k] <= lat[k] - 1;
        if (clr)                      mcnt[k] <= 0;
        else if ((exp_ctl(rem[k]) == STALL || mb) && mcnt[k] < cmax[k])
                                      mcnt[k] <= mcnt[k] + 1;
      end
    end
  end

  task automatic check(input string n, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      check($sformatf("model_ctl[%0d]", k), int'(act_ctl[k]), int'(exp_ctl(rem[k])));
      check($sformatf("model_cnt[%0d]", k), int'(act_cnt[k]), mcnt[k]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rs1 = 0; rs2 = 0; rd = 0; rs1_used = 0; rs2_used = 0;
    memread = 0; br = 0; mb = 0; clr = 0;
  endtask

  initial begin
    rst = 1'b0;
    idle_in();
    #3;
    for (int k = 0; k < 3; k++) begin
      check("reset_ctl", int'(act_ctl[k]), int'(NORMAL));
      check("reset_cnt", int'(act_cnt[k]), 0);
    end
    tick(); tick();
    rst = 1'b1;

    // lw x5 then use via rs1
    rs1 = 5; rs1_used = 1; rd = 5; memread = 1; #2;
    check("rs1_hazard_lat1", int'(act_ctl[0]), int'(STALL));
    check("rs1_hazard_lat3", int'(act_ctl[1]), int'(STALL));
    tick(); idle_in(); #2;
    check("lat1_done", int'(act_ctl[0]), int'(NORMAL));
    check("lat3_wait", int'(act_ctl[1]), int'(STALL));
    check("lat2_wait", int'(act_ctl[2]), int'(STALL));
    tick(); tick(); #2;
    check("lat1_cnt", int'(act_cnt[0]), 1);
    check("lat3_cnt", int'(act_cnt[1]), 3);
    check("lat2_cnt", int'(act_cnt[2]), 2);
    check("lat3_resume", int'(act_ctl[1]), int'(NORMAL));

    // dependency via rs2
    rs1 = 3; rs1_used = 1; rs2 = 7; rs2_used = 1; rd = 7; memread = 1; #2;
    check("rs2_hazard", int'(act_ctl[1]), int'(STALL));
    tick(); idle_in(); tick(); tick(); #2;
    check("rs2_lat3_cnt", int'(act_cnt[1]), 6);
    check("rs2_lat3_resume", int'(act_ctl[1]), int'(NORMAL));
    clr = 1; tick(); clr = 0; #2;
    check("clr_cnt", int'(act_cnt[1]), 0);

    // no-hazard cases: rd=x0, rs2 unused, not a load
    memread = 1; rd = 0; rs1 = 0; rs1_used = 1; #2;
    check("rd_zero", int'(act_ctl[1]), int'(NORMAL));
    tick(); idle_in();
    memread = 1; rd = 9; rs2 = 9; rs2_used = 0; rs1 = 1; rs1_used = 1; #2;
    check("rs2_unused", int'(act_ctl[1]), int'(NORMAL));
    tick(); idle_in();
    memread = 0; rd = 9; rs1 = 9; rs1_used = 1; #2;
    check("not_load", int'(act_ctl[1]), int'(NORMAL));
    tick(); idle_in(); #2;
    check("no_hazard_cnt", int'(act_cnt[1]), 0);

    // branch in second stall cycle aborts LOAD_WAIT
    rd = 4; rs1 = 4; rs1_used = 1; memread = 1;
    tick(); idle_in(); #2;
    check("pre_branch", int'(act_ctl[1]), int'(STALL));
    br = 1; #1;
    check("branch_flush_lat3", int'(act_ctl[1]), int'(FLUSH));
    check("branch_flush_lat2", int'(act_ctl[2]), int'(FLUSH));
    tick(); idle_in(); #2;
    check("post_branch_lat3", int'(act_ctl[1]), int'(NORMAL));
    check("post_branch_lat2", int'(act_ctl[2]), int'(NORMAL));
    check("branch_cnt", int'(act_cnt[1]), 1);

    // mem_busy during LOAD_WAIT
    clr = 1; tick(); clr = 0;
    rd = 6; rs2 = 6; rs2_used = 1; memread = 1;
    tick(); idle_in(); mb = 1; #2;
    check("freeze", int'(act_ctl[2]), int'(FREEZE));
    repeat (4) tick();
    mb = 0; #2;
    check("after_freeze_stall", int'(act_ctl[2]), int'(STALL));
    tick(); #2;
    check("after_freeze_done", int'(act_ctl[2]), int'(NORMAL));
    check("freeze_cnt", int'(act_cnt[2]), 6);
    tick();

    // counter saturation
    clr = 1; tick(); clr = 0;
    mb = 1; repeat (20) tick(); mb = 0; #2;
    check("sat_cnt4", int'(act_cnt[2]), 15);
    check("sat_cnt16", int'(act_cnt[1]), 20);
    clr = 1; tick(); clr = 0; #2;
    check("sat_clr", int'(act_cnt[2]), 0);

    // reset mid-LOAD_WAIT
    rd = 8; rs1 = 8; rs1_used = 1; memread = 1;
    tick(); idle_in(); #2;
    check("pre_reset_stall", int'(act_ctl[1]), int'(STALL));
    #1 rst = 1'b0;
    #1;
    check("async_reset_ctl", int'(act_ctl[1]), int'(NORMAL));
    check("async_reset_cnt", int'(act_cnt[1]), 0);
    tick(); tick();
    rst = 1'b1; #2;
    check("post_reset_idle", int'(act_ctl[1]), int'(NORMAL));
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Parametrised load-use hazard and pipeline-control unit for the 5-stage FemtoRV32 pipeline. Sits between decode (IF/ID), ID/EX and the memory interface.
- Detects load-use dependencies and holds the front end for a configurable load latency through a small FSM.
- Also applies branch flushes and global memory-wait freezes, and counts lost cycles in a saturating counter.
- Corrects register-operand usage qualification and precedence relative to the single-cycle combinational stall unit.

Parameters:
- REG_AW, 5, register address width.
- LOAD_LAT, 1, total stall cycles per load-use hazard (>=1).
- CNT_W, 16, width of stall_count.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-low reset.
- rs1_if_id  in  REG_AW  rs1 of the instruction in ID.
- rs2_if_id  in  REG_AW  rs2 of the instruction in ID.
- rs1_used  in  1  ID instruction reads rs1.
- rs2_used  in  1  ID instruction reads rs2.
- rd_id_ex  in  REG_AW  rd of the instruction in EX.
- memread_id_ex  in  1  EX instruction is a load.
- branch_taken  in  1  EX resolved a taken branch or jump.
- mem_busy  in  1  data/instruction memory not ready; whole pipeline must freeze.
- cnt_clr  in  1  synchronous clear of stall_count.
- stall  out  1  load-use stall active.
- pc_write  out  1  PC update enable.
- if_id_write  out  1  IF/ID register enable.
- id_ex_write  out  1  ID/EX register enable.
- id_ex_bubble  out  1  zero control fields entering ID/EX.
- if_id_flush  out  1  squash IF/ID.
- id_ex_flush  out  1  squash ID/EX.
- stall_count  out  CNT_W  cycles lost to stall or freeze.

Behaviour:
- hazard = memread_id_ex && rd_id_ex!=0 && ((rs1_used && rs1_if_id==rd_id_ex) || (rs2_used && rs2_if_id==rd_id_ex)).
- FSM states IDLE and LOAD_WAIT; down-counter wcnt of width clog2(LOAD_LAT)+1. All control outputs are combinational from the state, the inputs and wcnt.
- Priority per cycle: mem_busy > branch_taken > (LOAD_WAIT or hazard).
- mem_busy=1:
  - pc_write=if_id_write=id_ex_write=0; stall, bubble and flushes are 0.
  - FSM state and wcnt hold.
- branch_taken=1 (mem_busy=0):
  - if_id_flush=id_ex_flush=1; pc_write=if_id_write=id_ex_write=1; stall=0.
  - Next state IDLE, wcnt=0; this aborts any LOAD_WAIT.
- IDLE with hazard:
  - stall=1, pc_write=0, if_id_write=0, id_ex_bubble=1, id_ex_write=1.
  - If LOAD_LAT>1, next state LOAD_WAIT with wcnt=LOAD_LAT-1; otherwise remain in IDLE.
- LOAD_WAIT:
  - Same outputs as a hazard cycle, independent of the current ID/EX contents.
  - wcnt decrements each non-frozen cycle; when wcnt==1 at the edge, next state is IDLE.
- IDLE without hazard: pc_write=if_id_write=id_ex_write=1, all other control outputs 0.
- A load-use stall therefore lasts exactly LOAD_LAT non-frozen cycles.
- stall_count:
  - Increments by 1 on each cycle where stall=1 or mem_busy=1.
  - Saturates at 2^CNT_W-1.
  - cnt_clr has priority over increment: the next value is 0.
- Reset (rst=0, asynchronous):
  - State IDLE, wcnt=0, stall_count=0.
  - While rst=0 outputs are forced to pc_write=if_id_write=id_ex_write=1 and stall=id_ex_bubble=if_id_flush=id_ex_flush=0.
- Reset asserted mid-LOAD_WAIT aborts the stall immediately. After release, the unit starts in IDLE.

Test Plan:
- LOAD_LAT=1; lw x5 in EX (memread=1, rd=5), ID rs1=5, rs1_used=1 -> stall=1, pc_write=0, bubble=1 for 1 cycle; stall_count=1.
- LOAD_LAT=3, same dependency via rs2 -> stall high for exactly 3 consecutive cycles (IDLE, LOAD_WAIT x2), then pc_write=1; stall_count=3.
- rd=0 with memread=1 and rs1=0; or rs2 match with rs2_used=0; or rs1 match with memread=0 -> stall=0, stall_count unchanged.
- LOAD_LAT=3, branch_taken=1 in the second stall cycle -> if_id_flush=id_ex_flush=1, stall=0, state IDLE the next cycle.
- LOAD_LAT=2, mem_busy=1 for 4 cycles during LOAD_WAIT -> all write enables 0, wcnt held; after release 1 more stall cycle; stall_count=2+4=6.
- CNT_W=4, 20 cycles of mem_busy -> stall_count saturates at 15; cnt_clr=1 -> 0. rst low mid-LOAD_WAIT -> outputs immediately at reset values, count 0.
